router_merge_sched: RTL
=======================

Name: router_merge_sched

Overview:
- Scheduler that merges the two branch input FIFOs of the router into the trunk output path, one frame at a time.
- Per frame it latches the add/concatenate mode and pops both branch FIFOs in lock-step.
- It drives the merge datapath and trunk write strobe, meters writes with a credit counter against the downstream trunk FIFO, and flags stalled frames with a watchdog.
- Sits between the branch FIFO status flags and the trunk merge datapath inside the router.

Parameters:
- FIFO_DEPTH, 2, downstream trunk FIFO depth; reset/initial credit count.
- ADD_LAT, 1, adder pipeline latency in cycles (>=1).
- BEATS_PER_FRAME, 64, merged words per frame.
- CNT_W, 8, width of beat counter (2^CNT_W > BEATS_PER_FRAME).
- TIMEOUT, 100, max consecutive no-issue cycles in RUN before abort.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a frame when idle.
- sel_in  in  1  mode request: 1 = add, 0 = concatenate; sampled on accepted start.
- b1_empty  in  1  branch-1 FIFO empty.
- b2_empty  in  1  branch-2 FIFO empty.
- credit_return  in  1  downstream trunk FIFO freed one entry.
- b1_pop  out  1  pop branch-1 FIFO.
- b2_pop  out  1  pop branch-2 FIFO.
- dp_sel  out  1  latched mode to datapath.
- dp_valid  out  1  datapath input valid (equals issue).
- trunk_write  out  1  write strobe to trunk FIFO.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at frame completion.
- timeout_err  out  1  sticky watchdog flag.
- beat_cnt  out  CNT_W  beats issued in current frame.

Behaviour:
- Reset: state IDLE; all outputs 0 except dp_sel=1; credits=FIFO_DEPTH; latency shift register cleared, so no pending trunk_write survives reset; timeout counter 0.
- Reset mid-frame aborts the frame with no done pulse and clears timeout_err.
- IDLE -> RUN on start=1:
  - latch dp_sel<=sel_in;
  - clear beat_cnt and the watchdog counter;
  - timeout_err is not cleared by start.
- start in RUN or DRAIN is ignored.
- Issue (combinational, in RUN): !b1_empty && !b2_empty && credits>0 && beat_cnt<BEATS_PER_FRAME.
  - On issue: b1_pop=b2_pop=dp_valid=1; beat_cnt+1; credits-1.
  - Both branches are always popped together; never one alone.
- Credits:
  - credit_return alone: credits+1, saturating at FIFO_DEPTH (excess ignored).
  - Issue and credit_return in the same cycle: net unchanged.
  - credits==0 blocks issue.
- Latency: trunk_write asserts exactly L cycles after its issue cycle.
  - L = ADD_LAT when dp_sel=1; L = 1 when dp_sel=0.
  - Implemented as an ADD_LAT-deep shift register with a tap chosen by dp_sel.
  - Mode is constant within a frame, so order is preserved.
- RUN -> DRAIN in the cycle after the issue that makes beat_cnt==BEATS_PER_FRAME.
- DRAIN -> IDLE when the shift register is empty. done pulses for one cycle on that transition, in the same cycle as the final trunk_write or later.
- Watchdog:
  - In RUN, the counter increments on each cycle without issue and clears on issue.
  - On reaching TIMEOUT: set timeout_err; go to DRAIN.
  - In-flight writes complete; done still pulses; beat_cnt holds the partial count.
- busy = (state != IDLE).
- beat_cnt holds its value in IDLE until the next start.

Optional Feature:
- Macro ROUTER_MERGE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], counting RUN cycles with no issue, saturating at 16'hFFFF.
  - Cleared on accepted start and on rst; holds in IDLE/DRAIN.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Add mode, ADD_LAT=3, both FIFOs non-empty, credits returned each cycle, start with sel_in=1 -> 64 pops on consecutive cycles; trunk_write 3 cycles after each pop; done one cycle after the 64th write; beat_cnt=64.
- Concat mode, sel_in=0, same stimulus -> trunk_write 1 cycle after each pop; dp_sel=0 for the whole frame.
- b2_empty held high 5 cycles mid-frame with b1 non-empty -> no pops on either branch during those cycles; stall_cnt=5 with ROUTER_MERGE_STALL_CNT_EN.
- FIFO_DEPTH=2, no credit_return -> exactly 2 issues then stall; one credit_return -> exactly one further issue.
- Both FIFOs empty after start -> timeout_err=1 after 100 cycles; done pulses; beat_cnt=0; next start proceeds normally with timeout_err still 1.
- rst asserted with 2 beats in flight -> no trunk_write on the following cycles; busy=0, credits restored to FIFO_DEPTH.

Source files
------------

// File: rtl/router_merge_sched.sv
// router_merge_sched: merges the two branch FIFOs into the trunk path one
// frame at a time. Pops both branches in lock-step, meters trunk writes with
// a credit counter, delays the write strobe to match the datapath latency of
// the selected mode, and aborts stalled frames with a watchdog.
// Optional build macro ROUTER_MERGE_STALL_CNT_EN adds the stall_cnt output.
module router_merge_sched #(
    parameter int FIFO_DEPTH      = 2,
    parameter int ADD_LAT         = 1,
    parameter int BEATS_PER_FRAME = 64,
    parameter int CNT_W           = 8,
    parameter int TIMEOUT         = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel_in,
    input  logic             b1_empty,
    input  logic             b2_empty,
    input  logic             credit_return,
    output logic             b1_pop,
    output logic             b2_pop,
    output logic             dp_sel,
    output logic             dp_valid,
    output logic             trunk_write,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] beat_cnt
`ifdef ROUTER_MERGE_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int CRD_W = $clog2(FIFO_DEPTH + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [CRD_W-1:0] CRD_MAX    = CRD_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BEATS_ALL  = CNT_W'(BEATS_PER_FRAME);
    localparam logic [CNT_W-1:0] BEATS_M1   = CNT_W'(BEATS_PER_FRAME - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CRD_W-1:0]   credits;
    logic [WD_W-1:0]    wd_cnt;
    logic [ADD_LAT-1:0] vld_p;
    logic               issue;
    logic               frame_full;
    logic               wd_expire;
    logic               sr_empty;
    logic               start_ok;

    // A beat issues only when both branches have data, the trunk has room
    // and the frame is not yet complete.
    assign issue      = (state_q == S_RUN) && !b1_empty && !b2_empty &&
                        (credits != '0) && (beat_cnt < BEATS_ALL);
    assign frame_full = issue && (beat_cnt == BEATS_M1);
    assign wd_expire  = (state_q == S_RUN) && !issue && (wd_cnt == WD_LIMIT);
    assign sr_empty   = (vld_p == '0);
    assign start_ok   = (state_q == S_IDLE) && start;

    assign b1_pop   = issue;
    assign b2_pop   = issue;
    assign dp_valid = issue;
    assign busy     = (state_q != S_IDLE);

    // Add mode sees the full adder pipeline; concatenate is a single register.
    assign trunk_write = dp_sel ? vld_p[ADD_LAT-1] : vld_p[0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the frame-completion pulse.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (frame_full || wd_expire) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (sr_empty) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Per-frame mode latch and beat counter; the count holds in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_sel   <= 1'b1;
            beat_cnt <= '0;
        end else if (start_ok) begin
            dp_sel   <= sel_in;
            beat_cnt <= '0;
        end else if (issue) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Credit counter: issue spends, credit_return refunds, saturating at depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CRD_MAX;
        end else if (issue && !credit_return) begin
            credits <= credits - 1'b1;
        end else if (!issue && credit_return && (credits != CRD_MAX)) begin
            credits <= credits + 1'b1;
        end
    end

    // Issue-valid pipeline that times the trunk write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < ADD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Watchdog: counts consecutive no-issue RUN cycles; the error is sticky
    // across frames and only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (start_ok) begin
            wd_cnt <= '0;
        end else if (state_q == S_RUN) begin
            if (issue) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef ROUTER_MERGE_STALL_CNT_EN
    // Saturating count of RUN cycles without issue, per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if ((state_q == S_RUN) && !issue && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
